sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Sits directly downstream of the Wishbone-to-SDRAM port bridges, entirely in the SDRAM clock domain.
- Multiplexes NUM_PORTS internal port interfaces (adr/dat/sel/acc/we/ack) onto the single internal interface of the SDRAM controller.
- Uses round-robin grant with a post-ack hold window, so a port's two-burst refill (acc dropped on ack, re-raised a few cycles later) completes without being interleaved with another port.

Parameters:
- NUM_PORTS, 2, number of upstream ports (1..8).
- HOLD_CYCLES, 4, cycles the grant is held after the granted port drops acc, waiting for it to re-request (1..15).

Ports:
- sdram_clk  in  1  sole clock.
- sdram_rst  in  1  synchronous, active-high reset.
- port_adr_i  in  32*NUM_PORTS  per-port address, port k at [32k+31:32k].
- port_dat_i  in  16*NUM_PORTS  per-port write data.
- port_sel_i  in  2*NUM_PORTS  per-port byte selects.
- port_acc_i  in  NUM_PORTS  per-port access request.
- port_we_i  in  NUM_PORTS  per-port write enable.
- port_ack_o  out  NUM_PORTS  per-port acknowledge.
- port_dat_o  out  16  read data, broadcast to all ports.
- adr_o  out  32  to controller.
- dat_o  out  16  to controller.
- sel_o  out  2  to controller.
- acc_o  out  1  to controller.
- we_o  out  1  to controller.
- ack_i  in  1  from controller.
- dat_i  in  16  from controller.
- grant_o  out  NUM_PORTS  one-hot current owner, all zero in IDLE (debug/bench).

Behaviour:
- State machine states: IDLE, BUSY, HOLD. Registered: state, grant index, hold counter (4 bits), last-served pointer.
- Reset: state=IDLE, last pointer = NUM_PORTS-1 (so port 0 has first priority), counter=0.
- Reset outputs: acc_o=0, we_o=0, port_ack_o=0, grant_o=0. adr_o, dat_o and sel_o are driven 0 in IDLE.
- Reset mid-transaction: state returns to IDLE next cycle regardless of ack_i or acc.
- IDLE -> BUSY:
  - When any port_acc_i is high, register the grant to the first requesting port strictly after the last pointer, wrapping modulo NUM_PORTS.
  - Arbitration latency is 1 cycle: acc_o rises the cycle after the request is seen.
- BUSY:
  - adr_o, dat_o, sel_o and we_o are combinational muxes of the granted port. The port's address may change in the same cycle as ack_i and must pass straight through.
  - acc_o = granted port_acc_i.
  - If the granted acc is low, go to HOLD and load counter = HOLD_CYCLES-1. This covers acc falling on ack or without ack.
- HOLD:
  - acc_o=0, we_o=0; mux still selects the granted port.
  - If the granted acc rises, go to BUSY; acc_o follows in the same cycle, with no re-arbitration.
  - Else if counter==0: go to IDLE, set last pointer = granted index. Other ports' requests are evaluated in that IDLE cycle.
  - Else decrement the counter.
- Acknowledge routing:
  - port_ack_o[k] = ack_i & grant[k] & (state != IDLE); combinational, zero added latency.
  - ack_i in IDLE is dropped.
- Data: port_dat_o = dat_i, unregistered and broadcast. Ports qualify data themselves via their ack and counters.
- Requests from non-granted ports are ignored until the owner returns to IDLE. There is no preemption.
- Simultaneous requests: round-robin order only. With the pointer at p, candidates are p+1, p+2, … mod NUM_PORTS.
- NUM_PORTS=1: the pointer logic degenerates, but the hold/return-to-IDLE sequence is unchanged.

Decomposition:
- Shared package holds the state encoding (IDLE=0, BUSY=1, HOLD=2, 2-bit), the HOLD counter width constant, and the index width function clog2(NUM_PORTS).
- One sub-module, sdram_rr_pick: combinational round-robin picker.
  - Inputs: request vector, last pointer.
  - Outputs: valid, index.
  - Reusable and separately testable.

Test Plan:
- Single request, write: port0 acc=1 we=1 adr=0x100 → acc_o=1 on next cycle with adr_o=0x100 and we_o=1; ack_i pulse → port_ack_o=2'b01 same cycle; IDLE after 1+4 cycles of acc low.
- Two-burst read hold: port1 acc, ack at t, acc dropped, re-raised at t+3 → grant stays port1, acc_o=1 at t+3, port0 request at t+1 is not granted until port1 finishes.
- Hold expiry: port0 drops acc after ack and never re-raises → IDLE exactly HOLD_CYCLES cycles later; port1 pending request granted the following cycle.
- Round robin fairness: both ports request continuously with single-ack transactions → grants alternate 0,1,0,1; no port is granted twice in a row.
- Ack gating: ack_i pulsed in IDLE → all port_ack_o=0; ack_i in BUSY for port1 → port_ack_o=2'b10 only.
- Reset mid-BUSY: assert sdram_rst while acc_o=1 → next cycle acc_o=0, grant_o=0, state IDLE; first post-reset grant goes to port0 when both ports request.

Source files
------------

// File: rtl/sdram_port_arbiter_pkg.sv
// Shared constants for the SDRAM port arbiter: FSM encoding, hold counter
// width and the grant index width helper.
package sdram_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam int HOLD_CNT_W = 4;

  // A single port still needs a 1-bit index so vectors never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last,
// wrapping modulo NUM_PORTS; last itself has the lowest priority.
module sdram_rr_pick
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IW = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last,
  output logic                 valid,
  output logic [IW-1:0]        idx
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = int'(last) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = IW'(cand);
      if (req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter multiplexing NUM_PORTS bridge ports onto the single SDRAM
// controller interface, holding the grant briefly so two-burst refills stay atomic.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                    sdram_clk,
  input  logic                    sdram_rst,
  input  logic [32*NUM_PORTS-1:0] port_adr_i,
  input  logic [16*NUM_PORTS-1:0] port_dat_i,
  input  logic [2*NUM_PORTS-1:0]  port_sel_i,
  input  logic [NUM_PORTS-1:0]    port_acc_i,
  input  logic [NUM_PORTS-1:0]    port_we_i,
  output logic [NUM_PORTS-1:0]    port_ack_o,
  output logic [15:0]             port_dat_o,
  output logic [31:0]             adr_o,
  output logic [15:0]             dat_o,
  output logic [1:0]              sel_o,
  output logic                    acc_o,
  output logic                    we_o,
  input  logic                    ack_i,
  input  logic [15:0]             dat_i,
  output logic [NUM_PORTS-1:0]    grant_o,
  output logic [1:0]              fsm_state
);

  localparam int IW = idx_width(NUM_PORTS);

  // Handshake: a port holds acc high (with stable we) until the controller
  // returns ack for it; acc low means no request. ack is a single-cycle pulse
  // routed only to the current owner, and read data is valid in that cycle.

  logic [1:0]            state;
  logic [IW-1:0]         grant_idx;
  logic [IW-1:0]         last_ptr;
  logic [HOLD_CNT_W-1:0] hold_cnt;

  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;

  logic                  g_acc;
  logic                  g_we;
  logic [31:0]           g_adr;
  logic [15:0]           g_dat;
  logic [1:0]            g_sel;

  sdram_rr_pick #(
    .NUM_PORTS(NUM_PORTS)
  ) u_pick (
    .req   (port_acc_i),
    .last  (last_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign g_acc = port_acc_i[grant_idx];
  assign g_we  = port_we_i[grant_idx];
  assign g_adr = port_adr_i[32*grant_idx +: 32];
  assign g_dat = port_dat_i[16*grant_idx +: 16];
  assign g_sel = port_sel_i[2*grant_idx +: 2];

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state     <= ST_IDLE;
      grant_idx <= '0;
      last_ptr  <= IW'(NUM_PORTS - 1);
      hold_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state     <= ST_BUSY;
            grant_idx <= pick_idx;
          end
        end
        ST_BUSY: begin
          if (!g_acc) begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_CNT_W'(HOLD_CYCLES - 1);
          end
        end
        ST_HOLD: begin
          if (g_acc) begin
            state <= ST_BUSY;
          end else if (hold_cnt == '0) begin
            state    <= ST_IDLE;
            last_ptr <= grant_idx;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The owner's address/data pass straight through so an address change on
  // the ack cycle reaches the controller without a cycle of lag.
  always_comb begin
    adr_o      = '0;
    dat_o      = '0;
    sel_o      = '0;
    acc_o      = 1'b0;
    we_o       = 1'b0;
    grant_o    = '0;
    port_ack_o = '0;
    if (state != ST_IDLE) begin
      adr_o               = g_adr;
      dat_o               = g_dat;
      sel_o               = g_sel;
      acc_o               = g_acc;
      we_o                = (state == ST_BUSY) ? g_we : (g_we & g_acc);
      grant_o[grant_idx]    = 1'b1;
      port_ack_o[grant_idx] = ack_i;
    end
  end

  assign port_dat_o = dat_i;
  assign fsm_state  = state;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic,
// checked cycle by cycle against a transaction-level ownership model.
module tb_sdram_port_arbiter;
  import sdram_port_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int H  = 4;
  localparam int EW = 1 + 1 + 32 + 16 + 2 + N + N + 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [32*N-1:0] port_adr_i;
  logic [16*N-1:0] port_dat_i;
  logic [2*N-1:0]  port_sel_i;
  logic [N-1:0]    port_acc_i;
  logic [N-1:0]    port_we_i;
  logic [N-1:0]    port_ack_o;
  logic [15:0]     port_dat_o;
  logic [31:0]     adr_o;
  logic [15:0]     dat_o;
  logic [1:0]      sel_o;
  logic            acc_o;
  logic            we_o;
  logic            ack_i;
  logic [15:0]     dat_i;
  logic [N-1:0]    grant_o;
  logic [1:0]      fsm_state;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model: owner = -1 when nobody holds the interface.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_left  = 0;
  bit m_hold  = 1'b0;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .NUM_PORTS  (N),
    .HOLD_CYCLES(H)
  ) dut (
    .sdram_clk (clk),
    .sdram_rst (rst),
    .port_adr_i(port_adr_i),
    .port_dat_i(port_dat_i),
    .port_sel_i(port_sel_i),
    .port_acc_i(port_acc_i),
    .port_we_i (port_we_i),
    .port_ack_o(port_ack_o),
    .port_dat_o(port_dat_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .sel_o     (sel_o),
    .acc_o     (acc_o),
    .we_o      (we_o),
    .ack_i     (ack_i),
    .dat_i     (dat_i),
    .grant_o   (grant_o),
    .fsm_state (fsm_state)
  );

  // Expected outputs for this cycle, then the ownership update at the edge.
  always @(negedge clk) begin : ref_model
    logic          e_acc, e_we;
    logic [31:0]   e_adr;
    logic [15:0]   e_dat;
    logic [1:0]    e_sel;
    logic [N-1:0]  e_ack, e_grant;
    int            g, c;
    e_acc = 1'b0; e_we = 1'b0; e_adr = '0; e_dat = '0; e_sel = '0;
    e_ack = '0; e_grant = '0;
    g = m_owner;
    if (g >= 0) begin
      e_acc = port_acc_i[g];
      e_we  = m_hold ? (port_we_i[g] & port_acc_i[g]) : port_we_i[g];
      e_adr = port_adr_i[g*32 +: 32];
      e_dat = port_dat_i[g*16 +: 16];
      e_sel = port_sel_i[g*2 +: 2];
      e_grant[g] = 1'b1;
      if (ack_i) e_ack[g] = 1'b1;
    end
    exp_q.push_back({e_acc, e_we, e_adr, e_dat, e_sel, e_ack, e_grant, dat_i});

    if (rst) begin
      m_owner = -1; m_last = N - 1; m_left = 0; m_hold = 1'b0;
    end else if (m_owner < 0) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_last + i) % N;
        if (m_owner < 0 && port_acc_i[c]) m_owner = c;
      end
      m_hold = 1'b0;
    end else if (!m_hold) begin
      if (!port_acc_i[g]) begin
        m_hold = 1'b1;
        m_left = H;
      end
    end else if (port_acc_i[g]) begin
      m_hold = 1'b0;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_last  = g;
        m_owner = -1;
        m_hold  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [EW-1:0] e, got;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {acc_o, we_o, adr_o, dat_o, sel_o, port_ack_o, grant_o, port_dat_o};
      tests++;
      if (got !== e) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t got=%h exp=%h", $time, got, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] want);
    int n;
    n = 0;
    while (grant_o !== want && n < 20) begin
      tick();
      n++;
    end
    check(name, 32'(grant_o), 32'(want));
  endtask

  logic [N-1:0] seen;

  initial begin
    rst = 1'b1;
    port_adr_i = '0; port_dat_i = '0; port_sel_i = '0;
    port_acc_i = '0; port_we_i = '0;
    ack_i = 1'b0; dat_i = '0;

    tick();
    ack_i = 1'b1;
    #1;
    check("reset_acc", 32'(acc_o), 32'(0));
    check("reset_grant", 32'(grant_o), 32'(0));
    check("reset_ack_gated", 32'(port_ack_o), 32'(0));
    tick();
    rst = 1'b0;
    #1;
    check("idle_ack_gated", 32'(port_ack_o), 32'(0));
    ack_i = 1'b0;

    // Single write from port 0.
    port_acc_i = 2'b01; port_we_i = 2'b01;
    port_adr_i[31:0] = 32'h100; port_dat_i[15:0] = 16'hbeef; port_sel_i[1:0] = 2'b11;
    tick();
    check("wr_acc", 32'(acc_o), 32'(1));
    check("wr_adr", adr_o, 32'h100);
    check("wr_we", 32'(we_o), 32'(1));
    check("wr_grant", 32'(grant_o), 32'(2'b01));
    ack_i = 1'b1;
    #1;
    check("wr_ack_route", 32'(port_ack_o), 32'(2'b01));
    tick();
    ack_i = 1'b0; port_acc_i = '0; port_we_i = '0;
    repeat (4) tick();
    check("hold_before_expiry", 32'(fsm_state), 32'(ST_HOLD));
    tick();
    check("idle_after_hold", 32'(fsm_state), 32'(ST_IDLE));

    // Two-burst read on port 1 with port 0 knocking during the hold.
    port_acc_i = 2'b10; port_adr_i[63:32] = 32'h200;
    tick();
    check("burst_grant_p1", 32'(grant_o), 32'(2'b10));
    ack_i = 1'b1;
    #1;
    check("busy_ack_p1_only", 32'(port_ack_o), 32'(2'b10));
    tick();
    ack_i = 1'b0; port_acc_i = 2'b01;
    tick();
    check("hold_acc_low", 32'(acc_o), 32'(0));
    check("hold_keeps_p1", 32'(grant_o), 32'(2'b10));
    tick();
    port_acc_i = 2'b11; port_adr_i[63:32] = 32'h210;
    #1;
    check("reraise_acc_same_cycle", 32'(acc_o), 32'(1));
    check("reraise_adr", adr_o, 32'h210);
    tick();
    check("reraise_grant_p1", 32'(grant_o), 32'(2'b10));
    port_acc_i = 2'b01;
    wait_grant("p0_after_p1_done", 2'b01);

    // Reset while port 0 is being served.
    port_acc_i = 2'b11;
    #1;
    check("pre_rst_acc", 32'(acc_o), 32'(1));
    rst = 1'b1;
    tick();
    check("rst_mid_busy_acc", 32'(acc_o), 32'(0));
    check("rst_mid_busy_grant", 32'(grant_o), 32'(0));
    rst = 1'b0;
    tick();
    check("post_rst_p0_first", 32'(grant_o), 32'(2'b01));
    port_acc_i = '0;
    wait_grant("drain_to_idle", '0);

    // Randomized masters: hold acc until acked, then often drop and re-raise.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      seen = port_ack_o;
      tick();
      for (int k = 0; k < N; k++) begin
        if (port_acc_i[k] && seen[k] && $urandom_range(0, 3) != 0) port_acc_i[k] = 1'b0;
        else if (!port_acc_i[k] && $urandom_range(0, 3) == 0) port_acc_i[k] = 1'b1;
        if (!port_acc_i[k] || $urandom_range(0, 7) == 0) port_we_i[k] = 1'($urandom_range(0, 1));
        port_adr_i[k*32 +: 32] = $urandom;
        port_dat_i[k*16 +: 16] = 16'($urandom);
        port_sel_i[k*2 +: 2]   = 2'($urandom_range(0, 3));
      end
      ack_i = ($urandom_range(0, 2) == 0);
      dat_i = 16'($urandom);
      rst   = ($urandom_range(0, 299) == 0);
    end

    rst = 1'b0; port_acc_i = '0; ack_i = 1'b0;
    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
